// File: rtl/hit_manager_pkg.sv
// hit_manager_pkg: shared fight constants and the damage FSM state encoding
package hit_manager_pkg;
    localparam logic [3:0] FIGHT_STATE = 4'd1;
    localparam logic [9:0] H_LAST = 10'd639;
    localparam logic [9:0] V_LAST = 10'd479;
    typedef enum logic [1:0] {IDLE, ACTIVE, INVULN, DEAD} fsm_e;
endpackage

// File: rtl/hit_manager_frame_end_det.sv
// frame_end_det: one-cycle pulse on the cycle after the last visible pixel
module frame_end_det (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       frame_end
);
    import hit_manager_pkg::*;
    logic frame_end_q, frame_end_d;
    always_comb frame_end_d = (x == H_LAST) && (y == V_LAST);
    always_ff @(posedge clk) frame_end_q <= reset ? 1'b0 : frame_end_d;
    assign frame_end = frame_end_q;
endmodule

// File: rtl/hit_manager.sv
// hit_manager: heart/bullet overlap, once-per-frame damage, iframes, HP and game over
module hit_manager #(
    parameter int N_BULLETS = 3,
    parameter int MAX_HP    = 20,
    parameter int DAMAGE    = 4,
    parameter int IFRAMES   = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           state,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic                 heart_on,
    input  logic [N_BULLETS-1:0] bullet_on,
    output logic [N_BULLETS-1:0] collision,
    output logic [7:0]           hp,
    output logic                 hit_flash,
    output logic                 game_over
);
    import hit_manager_pkg::*;
    localparam logic [7:0] HP0 = 8'(MAX_HP);
    localparam logic [7:0] DMG = 8'(DAMAGE);
    localparam logic [7:0] IFR = 8'(IFRAMES);
    fsm_e fsm_q, fsm_d;
    logic [7:0] hp_q, hp_d, iframe_q, iframe_d;
    logic pending_q, pending_d, hit_flash_q, game_over_q, frame_end, leave, arm;
    logic [N_BULLETS-1:0] ovl, collision_q, collision_d;
    frame_end_det u_fed (
        .clk(clk),
        .reset(reset),
        .x(x),
        .y(y),
        .frame_end(frame_end)
    );
    assign leave = (fsm_q != DEAD) && (state != FIGHT_STATE);
    assign arm = (fsm_q == ACTIVE) || (fsm_q == INVULN);
    for (genvar i = 0; i < N_BULLETS; i++) begin : g_ovl
        assign ovl[i] = heart_on & bullet_on[i];
        assign collision_d[i] = leave ? 1'b0 : collision_q[i] | (ovl[i] & arm);
    end
    // frame_end lands on the first pixel of the next frame, so its overlap starts the new frame
    always_comb begin
        fsm_d = fsm_q;
        hp_d = hp_q;
        iframe_d = iframe_q;
        pending_d = (frame_end ? 1'b0 : pending_q) | (|ovl);
        if (leave) begin
            fsm_d = IDLE;
            iframe_d = '0;
            pending_d = 1'b0;
        end else begin
            case (fsm_q)
                IDLE: fsm_d = (hp_q == '0) ? DEAD : ACTIVE;
                ACTIVE: if (frame_end && pending_q) begin
                    hp_d = (hp_q <= DMG) ? '0 : hp_q - DMG;
                    fsm_d = (hp_d == '0) ? DEAD : INVULN;
                    iframe_d = (hp_d == '0) ? '0 : IFR;
                end
                INVULN: if (frame_end) begin
                    iframe_d = iframe_q - 8'd1;
                    fsm_d = (iframe_q == 8'd1) ? ACTIVE : INVULN;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q <= IDLE;
            hp_q <= HP0;
            iframe_q <= '0;
            pending_q <= 1'b0;
            collision_q <= '0;
            hit_flash_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            hp_q <= hp_d;
            iframe_q <= iframe_d;
            pending_q <= pending_d;
            collision_q <= collision_d;
            hit_flash_q <= fsm_d == INVULN;
            game_over_q <= fsm_d == DEAD;
        end
    end
    assign collision = collision_q;
    assign hp = hp_q;
    assign hit_flash = hit_flash_q;
    assign game_over = game_over_q;
endmodule

// File: tb/tb_hit_manager.sv
// tb_hit_manager: directed scoreboard bench for hit_manager using compressed frames
module tb_hit_manager;
    typedef struct {
        logic [2:0] c;
        logic [7:0] h;
        logic       f;
        logic       g;
    } exp_t;
    logic clk = 1'b0, reset = 1'b1, heart_on = 1'b0;
    logic [3:0] state = 4'd0;
    logic [9:0] x = 10'd0, y = 10'd0;
    logic [2:0] bullet_on = 3'b000, collision;
    logic [7:0] hp;
    logic hit_flash, game_over;
    exp_t sb[$];
    int total = 0, bad = 0;
    hit_manager dut (
        .clk(clk),
        .reset(reset),
        .state(state),
        .x(x),
        .y(y),
        .heart_on(heart_on),
        .bullet_on(bullet_on),
        .collision(collision),
        .hp(hp),
        .hit_flash(hit_flash),
        .game_over(game_over)
    );
    always #5 clk = ~clk;
    task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic [2:0] b, input logic hrt);
        @(negedge clk);
        x = px;
        y = py;
        bullet_on = b;
        heart_on = hrt;
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        pix(10'd100, 10'd100, 3'b000, 1'b0);
    endtask
    task automatic frame(input logic [2:0] b);
        if (b != 3'b000) pix(10'd100, 10'd100, b, 1'b1);
        pix(10'd639, 10'd479, 3'b000, 1'b1);
        pix(10'd0, 10'd0, 3'b000, 1'b0);
    endtask
    task automatic push(input logic [2:0] c, input logic [7:0] h, input logic f, input logic g);
        exp_t e;
        e.c = c;
        e.h = h;
        e.f = f;
        e.g = g;
        sb.push_back(e);
    endtask
    task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            cmp({tag, ".collision"}, 8'(collision), 8'(e.c));
            cmp({tag, ".hp"}, hp, e.h);
            cmp({tag, ".hit_flash"}, 8'(hit_flash), 8'(e.f));
            cmp({tag, ".game_over"}, 8'(game_over), 8'(e.g));
        end
    endtask
    task automatic do_reset();
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
    endtask
    initial begin
        do_reset();
        push(3'b000, 8'd20, 1'b0, 1'b0);
        chk("reset");
        state = 4'd1;
        idle();
        push(3'b000, 8'd20, 1'b0, 1'b0);
        pix(10'd100, 10'd100, 3'b010, 1'b0);
        chk("t1_no_heart");
        push(3'b010, 8'd20, 1'b0, 1'b0);
        pix(10'd100, 10'd100, 3'b010, 1'b1);
        chk("t1_coll");
        pix(10'd101, 10'd100, 3'b010, 1'b1);
        pix(10'd102, 10'd100, 3'b010, 1'b1);
        push(3'b010, 8'd20, 1'b0, 1'b0);
        pix(10'd639, 10'd479, 3'b000, 1'b0);
        chk("t1_pre_fe");
        push(3'b010, 8'd16, 1'b1, 1'b0);
        pix(10'd0, 10'd0, 3'b000, 1'b0);
        chk("t1_hit");
        do_reset();
        idle();
        for (int k = 0; k < 40; k++) begin
            push(3'b001, (k >= 31) ? 8'd12 : 8'd16, k != 30, 1'b0);
            frame(3'b001);
            chk($sformatf("t2_f%0d", k));
        end
        do_reset();
        idle();
        push(3'b101, 8'd20, 1'b0, 1'b0);
        pix(10'd200, 10'd50, 3'b101, 1'b1);
        chk("t3_coll");
        pix(10'd201, 10'd50, 3'b101, 1'b1);
        push(3'b101, 8'd16, 1'b1, 1'b0);
        frame(3'b000);
        chk("t3_hit");
        do_reset();
        idle();
        for (int h = 0; h < 5; h++) begin
            push(3'b001, (h == 4) ? 8'd0 : 8'(16 - 4 * h), h != 4, h == 4);
            frame(3'b001);
            chk($sformatf("t4_hit%0d", h));
            if (h < 4) begin
                for (int f = 0; f < 30; f++) frame(3'b000);
                push(3'b001, 8'(16 - 4 * h), 1'b0, 1'b0);
                chk($sformatf("t4_active%0d", h));
            end
        end
        frame(3'b100);
        push(3'b001, 8'd0, 1'b0, 1'b1);
        frame(3'b110);
        chk("t4_dead_ovl");
        state = 4'd2;
        push(3'b001, 8'd0, 1'b0, 1'b1);
        idle();
        chk("t4_dead_leave");
        state = 4'd1;
        do_reset();
        idle();
        push(3'b010, 8'd16, 1'b1, 1'b0);
        frame(3'b010);
        chk("t5_hit");
        for (int f = 0; f < 4; f++) frame(3'b000);
        state = 4'd2;
        push(3'b000, 8'd16, 1'b0, 1'b0);
        idle();
        chk("t5_leave");
        state = 4'd1;
        push(3'b000, 8'd16, 1'b0, 1'b0);
        idle();
        chk("t5_back");
        push(3'b010, 8'd12, 1'b1, 1'b0);
        frame(3'b010);
        chk("t5_rehit");
        do_reset();
        idle();
        push(3'b100, 8'd20, 1'b0, 1'b0);
        pix(10'd639, 10'd479, 3'b100, 1'b1);
        chk("t6_edge_coll");
        push(3'b100, 8'd16, 1'b1, 1'b0);
        pix(10'd0, 10'd0, 3'b000, 1'b0);
        chk("t6_edge_hit");
        idle();
        reset = 1'b1;
        push(3'b000, 8'd20, 1'b0, 1'b0);
        pix(10'd100, 10'd100, 3'b100, 1'b1);
        chk("t6_reset");
        reset = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
